fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 Parameter DEPTH, fixed at 2: instruction buffer entries, which is also the maximum number of outstanding requests.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 stall_f_i  input  1  hazard-unit hold; when 1, decode SHALL NOT consume the current fetch output.
REQ-006 redirect_i  input  1  branch/jump/exception redirect, one-cycle pulse.
REQ-007 redirect_pc_i  input  32  redirect target.
REQ-008 imem_req_o  output  1  fetch request valid.
REQ-009 imem_addr_o  output  32  fetch address, word-aligned.
REQ-010 imem_ready_i  input  1  memory accepts the request this cycle.
REQ-011 imem_valid_i  input  1  in-order read response valid.
REQ-012 imem_rdata_i  input  32  response instruction word.
REQ-013 instr_f_o  output  32  instruction presented to decode.
REQ-014 pc_plus_4_f_o  output  32  fetch PC of instr_f_o plus 4.
REQ-015 instr_valid_f_o  output  1  instr_f_o holds a real fetched instruction.

Function
REQ-016 Registers: pc_q (next fetch address), 2-entry FIFO of {pc_plus_4, instr}, out_cnt (0..2, outstanding requests), drop_cnt (0..2, responses to discard).
REQ-017 Request issue:
- imem_req_o = 1 iff not redirect_i and (out_cnt + fifo_count) < 2.
- imem_addr_o = pc_q.
- Issue is independent of stall_f_i.
REQ-018 Request accept: on a cycle with imem_req_o & imem_ready_i, the request is accepted; pc_q <= pc_q + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) and out_cnt increments.
REQ-019 An unaccepted request is not sticky; the address may change the next cycle, and memory treats it as cancelled.
REQ-020 Response handling:
- imem_valid_i with out_cnt = 0 SHALL be ignored.
- Otherwise out_cnt decrements.
- If drop_cnt > 0, the response is discarded and drop_cnt decrements.
- Else {address of that request + 4, imem_rdata_i} is pushed to the FIFO.
REQ-021 Accept and response in the same cycle leave out_cnt unchanged.
REQ-022 Output when the FIFO is non-empty: instr_f_o / pc_plus_4_f_o = FIFO head and instr_valid_f_o = 1.
REQ-023 Output when the FIFO is empty: instr_f_o = 32'h0000_0000 (NOP), pc_plus_4_f_o = pc_q, instr_valid_f_o = 0.
REQ-024 There is no response-to-output bypass. Latency is accept in cycle N, earliest response in N+1, instruction visible at output in N+2.
REQ-025 Pop: the head is popped at the clock edge iff the FIFO is non-empty and stall_f_i = 0.
REQ-026 Simultaneous push and pop on a full FIFO is impossible by REQ-017. Push and pop in the same cycle keep the count.
REQ-027 Redirect (redirect_i = 1), regardless of stall_f_i:
- FIFO cleared.
- pc_q <= {redirect_pc_i[31:2], 2'b00}.
- drop_cnt <= out_cnt minus any response arriving that same cycle.
- out_cnt updated per REQ-020.
- No request issued that cycle.
- The first request to the target is issued the next cycle.
REQ-028 A response arriving in the redirect cycle SHALL be discarded, never pushed.
REQ-029 The FIFO SHALL never overflow. out_cnt + fifo_count <= 2 at all times.

Reset
REQ-030 While rst_i = 0:
- pc_q = RESET_PC; FIFO empty; out_cnt = drop_cnt = 0.
- imem_req_o = 0, instr_valid_f_o = 0, instr_f_o = 0, pc_plus_4_f_o = RESET_PC.
REQ-031 Reset mid-operation abandons outstanding responses. The memory is reset by the same rst_i.
REQ-032 First request: imem_req_o = 1 with imem_addr_o = RESET_PC in the first cycle after rst_i deasserts.

Verification
REQ-033 Streaming: ready = 1 always, 1-cycle response latency, stall = 0, RESET_PC = 0.
-> Outputs instr at 0, 4, 8, ... one per cycle from cycle 2.
-> pc_plus_4_f_o = 4, 8, 12, ...
REQ-034 Backpressure: stall_f_i held 1 for 5 cycles.
-> Exactly 2 accepted requests, then imem_req_o = 0.
-> Output frozen on instr@0.
-> After release, instr@4 follows without loss or duplication.
REQ-035 Redirect with 2 outstanding: redirect_i to 32'h0000_1003.
-> Both old responses discarded.
-> Next imem_addr_o = 32'h0000_1000.
-> First valid output is instr@0x1000 with pc_plus_4 = 0x1004.
REQ-036 Simultaneous events: redirect in the same cycle as a response and a stall.
-> Response dropped, FIFO empty next cycle, instr_valid_f_o = 0, instr_f_o = 0.
REQ-037 Wrap: RESET_PC = 32'hFFFF_FFF8.
-> Fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
-> pc_plus_4 values FFFF_FFFC, 0000_0000, 0000_0004.
REQ-038 Async reset asserted mid-stream between clock edges.
-> Outputs take reset values immediately.
-> Stray imem_valid_i pulses after deassert, with out_cnt = 0, are ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 2-entry instruction buffer.
//   clk_i          : clock, all state updates on rising edge
//   rst_i          : asynchronous active-low reset
//   stall_f_i      : decode hold, head of buffer is not consumed while 1
//   redirect_i     : one-cycle redirect pulse (branch/jump/exception)
//   redirect_pc_i  : redirect target, low two bits ignored
//   imem_req_o     : fetch request valid
//   imem_addr_o    : word-aligned fetch address
//   imem_ready_i   : memory accepts the request this cycle
//   imem_valid_i   : in-order read response valid
//   imem_rdata_i   : response instruction word
//   instr_f_o      : instruction to decode (NOP when buffer empty)
//   pc_plus_4_f_o  : fetch PC of instr_f_o plus 4 (pc_q when buffer empty)
//   instr_valid_f_o: instr_f_o holds a real fetched instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_f_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_f_o,
    output logic [31:0] pc_plus_4_f_o,
    output logic        instr_valid_f_o
);
    // Buffer entry layout: {pc_plus_4, instr}
    logic [1:0][63:0] fifo_q, fifo_d;
    logic [31:0]      pc_q, pc_d;
    // Address of the request whose response will be kept next. Kept responses
    // always belong to the sequential stream started at the last redirect.
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [1:0]       out_cnt_q, out_cnt_d;
    logic [1:0]       drop_cnt_q, drop_cnt_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             rd_ptr_q, rd_ptr_d;

    logic        resp, accept, push, pop, wr_idx;
    logic [2:0]  inflight;
    logic [31:0] target;
    logic [63:0] head;
    logic        unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        target     = {redirect_pc_i[31:2], 2'b00};
        inflight   = {1'b0, out_cnt_q} + {1'b0, cnt_q};
        // Gated by reset so the request stays low while rst_i is held.
        imem_req_o = rst_i && !redirect_i && (inflight < 3'(DEPTH));
        imem_addr_o = pc_q;
        accept     = imem_req_o && imem_ready_i;
        resp       = imem_valid_i && (out_cnt_q != 2'd0);
        push       = resp && (drop_cnt_q == 2'd0) && !redirect_i;
        pop        = (cnt_q != 2'd0) && !stall_f_i;
        // A push only happens with cnt_q <= 1, so the slot after the head is free.
        wr_idx     = rd_ptr_q ^ cnt_q[0];
        out_cnt_d  = out_cnt_q + {1'b0, accept} - {1'b0, resp};
        drop_cnt_d = redirect_i ? out_cnt_q - {1'b0, resp}
                                : drop_cnt_q - {1'b0, resp && (drop_cnt_q != 2'd0)};
        cnt_d      = redirect_i ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d   = redirect_i ? 1'b0 : rd_ptr_q ^ pop;
        pc_d       = redirect_i ? target : (accept ? pc_q + 32'd4 : pc_q);
        resp_pc_d  = redirect_i ? target : (push ? resp_pc_q + 32'd4 : resp_pc_q);
        fifo_d     = fifo_q;
        if (push)
            fifo_d[wr_idx] = {resp_pc_q + 32'd4, imem_rdata_i};
        head            = fifo_q[rd_ptr_q];
        instr_valid_f_o = cnt_q != 2'd0;
        instr_f_o       = instr_valid_f_o ? head[31:0] : 32'h0000_0000;
        pc_plus_4_f_o   = instr_valid_f_o ? head[63:32] : pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= 2'd0;
            drop_cnt_q <= 2'd0;
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            fifo_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with memory model and output scoreboard.
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_f_i, redirect_i, imem_ready_i, imem_valid_i;
    logic [31:0] redirect_pc_i, imem_rdata_i;
    logic        imem_req_o, instr_valid_f_o;
    logic [31:0] imem_addr_o, instr_f_o, pc_plus_4_f_o;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc4;

    int          n_cmp = 0, n_bad = 0, n_acc = 0, n_out = 0;
    bit          mem_on = 1'b1;
    ent_t        exp_q[$];
    logic [31:0] mq[$];
    logic [31:0] acc_log[$];

    always #5 clk_i = ~clk_i;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_f_i(stall_f_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
        .instr_f_o(instr_f_o), .pc_plus_4_f_o(pc_plus_4_f_o), .instr_valid_f_o(instr_valid_f_o)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .stall_f_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ready_i(1'b0), .imem_valid_i(1'b0), .imem_rdata_i(32'h0),
        .instr_f_o(w_instr), .pc_plus_4_f_o(w_pc4), .instr_valid_f_o(w_valid)
    );

    function automatic logic [31:0] code(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: score the output mid-cycle, record accepted requests,
    // then let the memory answer one cycle after acceptance.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge clk_i);
        if (instr_valid_f_o) begin
            chk1("sb_has_entry", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                chk("sb_instr", instr_f_o, exp_q[0].instr);
                chk("sb_pc4", pc_plus_4_f_o, exp_q[0].pc4);
                if (!stall_f_i) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end else
            chk("sb_nop", instr_f_o, 32'h0);
        if (redirect_i)
            exp_q.delete();
        acc = imem_req_o && imem_ready_i;
        a   = imem_addr_o;
        if (acc) begin
            exp_q.push_back({a + 32'd4, code(a)});
            acc_log.push_back(a);
            n_acc++;
        end
        @(posedge clk_i);
        #1;
        redirect_i = 1'b0;
        if (rst_i) begin
            if (acc)
                mq.push_back(a);
            if (mem_on && mq.size() != 0) begin
                imem_valid_i = 1'b1;
                imem_rdata_i = code(mq.pop_front());
            end else
                imem_valid_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_i        = 1'b0;
        imem_valid_i = 1'b0;
        mq.delete();
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        n_acc = 0;
        n_out = 0;
        acc_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_i = 1'b0; stall_f_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_ready_i = 1'b1; imem_valid_i = 1'b0; imem_rdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        chk1("rst_req", imem_req_o, 1'b0);
        chk1("rst_valid", instr_valid_f_o, 1'b0);
        chk("rst_instr", instr_f_o, 32'h0);
        chk("rst_pc4", pc_plus_4_f_o, 32'h0);
        chk("wrap_rst_pc4", w_pc4, 32'hFFFF_FFF8);
        chk1("wrap_rst_req", w_req, 1'b0);
        rst_i = 1'b1;
        #1;
        chk1("first_req", imem_req_o, 1'b1);
        chk("first_addr", imem_addr_o, 32'h0);
        chk1("wrap_first_req", w_req, 1'b1);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFF8);

        // streaming: first instruction visible two cycles after the first accept
        tick(); #1;
        chk1("lat_c1_valid", instr_valid_f_o, 1'b0);
        tick(); #1;
        chk1("lat_c2_valid", instr_valid_f_o, 1'b1);
        chk("lat_c2_instr", instr_f_o, code(32'h0));
        chk("lat_c2_pc4", pc_plus_4_f_o, 32'h4);
        repeat (12) tick();
        chk1("stream_count", n_out >= 6, 1'b1);

        // backpressure
        do_reset();
        stall_f_i = 1'b1;
        repeat (5) tick();
        #1;
        chk("bp_accepts", n_acc, 32'd2);
        chk1("bp_req", imem_req_o, 1'b0);
        chk1("bp_valid", instr_valid_f_o, 1'b1);
        chk("bp_frozen_instr", instr_f_o, code(32'h0));
        chk("bp_frozen_pc4", pc_plus_4_f_o, 32'h4);
        stall_f_i = 1'b0;
        tick(); #1;
        chk("bp_next_instr", instr_f_o, code(32'h4));
        chk("bp_next_pc4", pc_plus_4_f_o, 32'h8);
        repeat (6) tick();

        // redirect with two requests outstanding
        do_reset();
        mem_on = 1'b0;
        tick(); tick(); #1;
        chk1("rd_out2_req", imem_req_o, 1'b0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_1003; mem_on = 1'b1;
        #1;
        chk1("rd_cycle_req", imem_req_o, 1'b0);
        tick(); #1;
        chk("rd_next_addr", imem_addr_o, 32'h0000_1000);
        k = 0;
        while (!instr_valid_f_o && k < 20) begin
            tick(); #1;
            k++;
        end
        chk1("rd_first_valid", instr_valid_f_o, 1'b1);
        chk("rd_first_instr", instr_f_o, code(32'h0000_1000));
        chk("rd_first_pc4", pc_plus_4_f_o, 32'h0000_1004);
        repeat (6) tick();

        // redirect coinciding with a response and a stall
        do_reset();
        tick(); #1;
        chk1("sim_resp_due", imem_valid_i, 1'b1);
        stall_f_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000;
        tick(); #1;
        chk1("sim_valid", instr_valid_f_o, 1'b0);
        chk("sim_instr", instr_f_o, 32'h0);
        chk("sim_pc4", pc_plus_4_f_o, 32'h0000_2000);
        chk1("sim_req", imem_req_o, 1'b1);
        chk("sim_addr", imem_addr_o, 32'h0000_2000);
        stall_f_i = 1'b0;
        repeat (8) tick();

        // address wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        acc_log.delete();
        repeat (12) tick();
        chk1("wrap_n", acc_log.size() >= 3, 1'b1);
        if (acc_log.size() >= 3) begin
            chk("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
            chk("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
            chk("wrap_a2", acc_log[2], 32'h0000_0000);
        end

        // asynchronous reset between edges, then stray responses
        #3;
        rst_i = 1'b0;
        #1;
        chk1("arst_req", imem_req_o, 1'b0);
        chk1("arst_valid", instr_valid_f_o, 1'b0);
        chk("arst_instr", instr_f_o, 32'h0);
        chk("arst_pc4", pc_plus_4_f_o, 32'h0);
        chk("arst_wrap_pc4", w_pc4, 32'hFFFF_FFF8);
        mq.delete(); exp_q.delete();
        imem_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        mem_on = 1'b0; imem_ready_i = 1'b0;
        imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick(); #1;
        chk1("stray_valid", instr_valid_f_o, 1'b0);
        chk("stray_instr", instr_f_o, 32'h0);
        imem_ready_i = 1'b1; mem_on = 1'b1;
        k = 0;
        while (!instr_valid_f_o && k < 20) begin
            tick(); #1;
            k++;
        end
        chk1("post_stray_valid", instr_valid_f_o, 1'b1);
        chk("post_stray_instr", instr_f_o, code(32'h0));
        chk("post_stray_pc4", pc_plus_4_f_o, 32'h4);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
